master_port: RTL and testbench
==============================

Name: master_port

Overview:
- Per-master bus interface that sits directly upstream of the bus arbiter.
- Accepts one parallel read/write request from a local master device and raises breq to the arbiter.
- After bgrant, serialises address and write data onto the bus and deserialises read data from the slave.
- Handles arbiter split suspend/resume (msplit) without losing transfer progress.

Parameters:
ADDR_WIDTH, 16, address bits sent per transaction
DATA_WIDTH, 8, data bits per transaction
ACK_TIMEOUT, 8, cycles to wait for slave address ack before aborting

Ports:
clk  input  1  system clock, rising edge
rstn  input  1  asynchronous active-low reset
dvalid  input  1  local request strobe, sampled only when dready=1
dmode  input  1  0 = read, 1 = write
daddr  input  ADDR_WIDTH  local request address
dwdata  input  DATA_WIDTH  local write data
dready  output  1  port idle, request can be accepted
drdata  output  DATA_WIDTH  read data, valid from the ddone cycle until the next ddone
ddone  output  1  one-cycle pulse: transaction completed
derror  output  1  one-cycle pulse: transaction aborted
breq  output  1  bus request to arbiter
bgrant  input  1  bus grant from arbiter
msplit  input  1  split indication from arbiter for this master
mwdata  output  1  serial address/write-data bit
mvalid  output  1  mwdata bit valid
mmode  output  1  latched mode, driven whenever breq=1
ack  input  1  slave address acknowledge
mrdata  input  1  serial read-data bit from slave
svalid  input  1  mrdata bit valid

Behaviour:
- Reset (async, rstn=0): state IDLE, all counters/regs cleared.
  - Output values in reset: dready=1, breq=0, mvalid=0, mwdata=0, mmode=0, ddone=0, derror=0, drdata=0.
  - Reset mid-transaction abandons the transfer immediately; no ddone/derror pulse is produced.
- States: IDLE, REQ, ADDR, ACKW, WDATA, RDATA, SPLIT, DONE, ABORT.
- IDLE: dready=1.
  - dvalid=1 latches daddr, dwdata and dmode.
  - Next state REQ.
- REQ: breq=1.
  - bgrant=1 sampled -> ADDR.
  - No timeout; breq is held indefinitely.
- breq=1 in every state except IDLE, DONE and ABORT, including SPLIT.
  - This is required so that the arbiter's resumed grant is not dropped.
- ADDR: mvalid=1 for exactly ADDR_WIDTH cycles.
  - mwdata carries the latched address, LSB first; bit counter from 0 to ADDR_WIDTH-1.
  - Then -> ACKW.
- ACKW: mvalid=0. A timeout counter starts at 0.
  - ack=1 -> WDATA if mmode=1, RDATA if mmode=0.
  - ACK_TIMEOUT cycles without ack -> ABORT.
  - ack arriving in the same cycle the counter reaches ACK_TIMEOUT is accepted; ack wins.
- WDATA: mvalid=1 for DATA_WIDTH cycles, data LSB first. Then -> DONE.
- RDATA: each cycle with svalid=1 shifts mrdata into the read shift register, LSB first, and increments the bit counter.
  - After the DATA_WIDTH-th bit -> DONE.
  - msplit=1 -> SPLIT. The bit counter and partial data are preserved.
  - If svalid and msplit are both 1 in the same cycle, the bit is captured first.
- SPLIT: breq=1, mvalid=0.
  - When msplit=0 and bgrant=1 -> return to RDATA and continue from the saved bit count.
- Grant loss: bgrant=0 in ADDR, ACKW, WDATA or RDATA while msplit=0 -> ABORT.
- DONE (1 cycle): ddone=1, breq=0.
  - For a read, drdata is loaded from the shift register in this cycle.
  - Next state IDLE.
- ABORT (1 cycle): derror=1, breq=0, drdata unchanged. Next state IDLE.
- Latency (write, immediate bgrant, ack in first ACKW cycle):
  - dvalid accepted at edge 0; breq high in cycle 1; ADDR starts in cycle 2.
  - ddone occurs in cycle 2 + ADDR_WIDTH + 1 + DATA_WIDTH.
- All outputs are decoded from registered state/counters; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package (bus_pkg): state encodings; MODE_READ=0, MODE_WRITE=1; default ADDR_WIDTH and DATA_WIDTH constants, so the slave port and arbiter bench can use the same values.
- One sub-module: serial_shifter, a parameterised PISO/SIPO register with load, shift-enable and bit counter, instantiated once and shared between the ADDR, WDATA and RDATA phases.

Test Plan:
- Write 0xA5 to 0x1234, bgrant in REQ, ack one cycle after ADDR -> mwdata LSB-first 16 address bits then 1,0,1,0,0,1,0,1; ddone in cycle 27; breq falls in the same cycle.
- Read with slave returning 0x3C, svalid held 1 -> drdata=0x3C at the ddone cycle; no mvalid during RDATA.
- Read with msplit asserted after 3 bits, released 10 cycles later with bgrant=1 -> breq stays 1 throughout; remaining 5 bits captured; drdata correct.
- No ack for 8 cycles after ADDR -> derror pulse, breq=0, return to IDLE; the next request is accepted.
- bgrant dropped mid-WDATA (msplit=0) -> ABORT: derror=1 for 1 cycle, mvalid=0 from the next cycle.
- rstn pulled low mid-ADDR, asynchronously between edges -> breq/mvalid go 0 immediately; dready=1; no ddone/derror pulse.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared bus definitions: master port state encoding, transfer modes and default widths
// used by the master port, slave port and arbiter bench.
package bus_pkg;

    localparam int ADDR_WIDTH_DEF  = 16;
    localparam int DATA_WIDTH_DEF  = 8;
    localparam int ACK_TIMEOUT_DEF = 8;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_REQ   = 4'd1,
        ST_ADDR  = 4'd2,
        ST_ACKW  = 4'd3,
        ST_WDATA = 4'd4,
        ST_RDATA = 4'd5,
        ST_SPLIT = 4'd6,
        ST_DONE  = 4'd7,
        ST_ABORT = 4'd8
    } mp_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/serial_shifter.sv
// Combined PISO/SIPO register: loads in parallel, shifts right with the serial input
// entering at the MSB, and counts shifted bits. sout_o is always the current LSB.
module serial_shifter #(
    parameter int WIDTH = 16,
    parameter int PW    = 8,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             shift_i,
    input  logic             sin_i,
    output logic             sout_o,
    output logic [PW-1:0]    par_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Shift register and bit counter state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_q <= {WIDTH{1'b0}};
            cnt_q  <= {CNT_W{1'b0}};
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    // Clear has priority over load, load over shift
    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        if (clr_i) begin
            data_d = {WIDTH{1'b0}};
            cnt_d  = {CNT_W{1'b0}};
        end else if (load_i) begin
            data_d = load_val_i;
            cnt_d  = {CNT_W{1'b0}};
        end else if (shift_i) begin
            data_d = {sin_i, data_q[WIDTH-1:1]};
            cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            data_d = data_q;
            cnt_d  = cnt_q;
        end
    end

    assign sout_o  = data_q[0];
    assign par_o   = data_q[WIDTH-1 -: PW];
    assign count_o = cnt_q;

endmodule

// File: rtl/master_port.sv
// Per-master bus port: takes one parallel request, arbitrates via breq/bgrant, then
// serialises address/write data and deserialises read data, surviving arbiter splits.
module master_port
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  dvalid,
    input  logic                  dmode,
    input  logic [ADDR_WIDTH-1:0] daddr,
    input  logic [DATA_WIDTH-1:0] dwdata,
    output logic                  dready,
    output logic [DATA_WIDTH-1:0] drdata,
    output logic                  ddone,
    output logic                  derror,
    output logic                  breq,
    input  logic                  bgrant,
    input  logic                  msplit,
    output logic                  mwdata,
    output logic                  mvalid,
    output logic                  mmode,
    input  logic                  ack,
    input  logic                  mrdata,
    input  logic                  svalid
);

    localparam int SH_W  = max_int(ADDR_WIDTH, DATA_WIDTH);
    localparam int CNT_W = $clog2(SH_W + 1);
    localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);

    mp_state_e             state_q, state_d;
    logic                  mode_q, mode_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] drdata_q, drdata_d;
    logic [TO_W-1:0]       to_q, to_d;

    logic                  sh_clr, sh_load, sh_shift, sh_sout;
    logic [SH_W-1:0]       sh_load_val;
    logic [DATA_WIDTH-1:0] sh_par;
    logic [CNT_W-1:0]      sh_cnt;
    logic                  grant_lost;
    logic                  addr_last, data_last;
    logic [DATA_WIDTH-1:0] rd_next;

    serial_shifter #(
        .WIDTH (SH_W),
        .PW    (DATA_WIDTH),
        .CNT_W (CNT_W)
    ) u_shifter (
        .clk        (clk),
        .rstn       (rstn),
        .clr_i      (sh_clr),
        .load_i     (sh_load),
        .load_val_i (sh_load_val),
        .shift_i    (sh_shift),
        .sin_i      (mrdata),
        .sout_o     (sh_sout),
        .par_o      (sh_par),
        .count_o    (sh_cnt)
    );

    // During a split the arbiter legitimately withdraws the grant, so only a bare drop aborts
    assign grant_lost = !bgrant && !msplit;
    assign addr_last  = (sh_cnt == CNT_W'(ADDR_WIDTH - 1));
    assign data_last  = (sh_cnt == CNT_W'(DATA_WIDTH - 1));
    assign rd_next    = {mrdata, sh_par[DATA_WIDTH-1:1]};

    // State and latched request registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_READ;
            wdata_q  <= {DATA_WIDTH{1'b0}};
            drdata_q <= {DATA_WIDTH{1'b0}};
            to_q     <= {TO_W{1'b0}};
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            wdata_q  <= wdata_d;
            drdata_q <= drdata_d;
            to_q     <= to_d;
        end
    end

    // Next-state and shifter control
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        wdata_d     = wdata_q;
        drdata_d    = drdata_q;
        to_d        = to_q;
        sh_clr      = 1'b0;
        sh_load     = 1'b0;
        sh_load_val = {SH_W{1'b0}};
        sh_shift    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (dvalid) begin
                    mode_d      = dmode;
                    wdata_d     = dwdata;
                    sh_load     = 1'b1;
                    sh_load_val = SH_W'(daddr);
                    state_d     = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (bgrant) begin
                    state_d = ST_ADDR;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_ADDR: begin
                if (grant_lost) begin
                    state_d = ST_ABORT;
                end else begin
                    sh_shift = 1'b1;
                    if (addr_last) begin
                        to_d    = {TO_W{1'b0}};
                        state_d = ST_ACKW;
                    end else begin
                        state_d = ST_ADDR;
                    end
                end
            end
            ST_ACKW: begin
                // ack is examined before the timeout so a late ack still wins
                if (grant_lost) begin
                    state_d = ST_ABORT;
                end else if (ack) begin
                    if (mode_q == MODE_WRITE) begin
                        sh_load     = 1'b1;
                        sh_load_val = SH_W'(wdata_q);
                        state_d     = ST_WDATA;
                    end else begin
                        sh_clr  = 1'b1;
                        state_d = ST_RDATA;
                    end
                end else if (to_q == TO_W'(ACK_TIMEOUT)) begin
                    state_d = ST_ABORT;
                end else begin
                    to_d = to_q + {{(TO_W-1){1'b0}}, 1'b1};
                end
            end
            ST_WDATA: begin
                if (grant_lost) begin
                    state_d = ST_ABORT;
                end else begin
                    sh_shift = 1'b1;
                    if (data_last) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WDATA;
                    end
                end
            end
            ST_RDATA: begin
                if (grant_lost) begin
                    state_d = ST_ABORT;
                end else if (svalid) begin
                    sh_shift = 1'b1;
                    if (data_last) begin
                        drdata_d = rd_next;
                        state_d  = ST_DONE;
                    end else if (msplit) begin
                        state_d = ST_SPLIT;
                    end else begin
                        state_d = ST_RDATA;
                    end
                end else if (msplit) begin
                    state_d = ST_SPLIT;
                end else begin
                    state_d = ST_RDATA;
                end
            end
            ST_SPLIT: begin
                if (!msplit && bgrant) begin
                    state_d = ST_RDATA;
                end else begin
                    state_d = ST_SPLIT;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_ABORT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign dready = (state_q == ST_IDLE);
    assign breq   = (state_q != ST_IDLE) && (state_q != ST_DONE) && (state_q != ST_ABORT);
    assign mvalid = (state_q == ST_ADDR) || (state_q == ST_WDATA);
    assign mwdata = mvalid && sh_sout;
    assign mmode  = breq && mode_q;
    assign ddone  = (state_q == ST_DONE);
    assign derror = (state_q == ST_ABORT);
    assign drdata = drdata_q;

endmodule

// File: tb/tb_master_port.sv
// Bench for master_port: per-cycle schedules and expected outputs are derived from the
// transaction-level protocol rules, then compared cycle by cycle against the DUT.
module tb_master_port;

    localparam int AW   = 16;
    localparam int DW   = 8;
    localparam int TO   = 8;
    localparam int MAXC = 64;

    logic          clk = 1'b0;
    logic          rstn;
    logic          dvalid, dmode, bgrant, msplit, ack, mrdata, svalid;
    logic [AW-1:0] daddr;
    logic [DW-1:0] dwdata, drdata;
    logic          dready, ddone, derror, breq, mwdata, mvalid, mmode;

    always #5 clk = ~clk;

    master_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ACK_TIMEOUT(TO)) dut (
        .clk(clk), .rstn(rstn), .dvalid(dvalid), .dmode(dmode), .daddr(daddr),
        .dwdata(dwdata), .dready(dready), .drdata(drdata), .ddone(ddone),
        .derror(derror), .breq(breq), .bgrant(bgrant), .msplit(msplit),
        .mwdata(mwdata), .mvalid(mvalid), .mmode(mmode), .ack(ack),
        .mrdata(mrdata), .svalid(svalid)
    );

    int checks = 0;
    int fails  = 0;

    // Per-cycle stimulus schedule and expected/observed vectors
    // vector bits: {dready, breq, mmode, mvalid, mwdata, ddone, derror}
    logic          bg_s[MAXC], ack_s[MAXC], sv_s[MAXC], ms_s[MAXC], mr_s[MAXC];
    logic [6:0]    exp_v[MAXC], obs_v[MAXC];
    logic [DW-1:0] obs_rd[MAXC];
    int            n_cyc, end_cyc;
    logic [DW-1:0] model_rd;
    logic          exp_rd_load;

    // Build the schedule from the protocol rules: d = ack delay in ACKW (-1: never),
    // k = bits before a read split (0: none), l = split length, sw = split coincides
    // with bit k-1, gd = write data bit index at which the grant drops (-1: never).
    task automatic plan(input logic mode, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                        input logic [DW-1:0] sd, input int d, input int k, input int l,
                        input int sw, input int gd);
        int c, e, p, s;
        logic abrt;
        for (int i = 0; i < MAXC; i++) begin
            bg_s[i] = (i >= 1); ack_s[i] = 1'b0; sv_s[i] = 1'b0; ms_s[i] = 1'b0;
            mr_s[i] = 1'b0; exp_v[i] = 7'b0;
        end
        exp_v[0][6] = 1'b1;
        for (int i = 0; i < AW; i++) begin
            exp_v[2+i][3] = 1'b1;
            exp_v[2+i][2] = addr[i];
        end
        abrt = 1'b0;
        e = 0;
        if (d < 0) begin
            e = 2 + AW + TO + 1;
            abrt = 1'b1;
        end else begin
            ack_s[2+AW+d] = 1'b1;
            p = 3 + AW + d;
            if (mode) begin
                e = p + DW;
                for (int j = 0; j < DW; j++) begin
                    exp_v[p+j][3] = 1'b1;
                    exp_v[p+j][2] = wd[j];
                    if (j == gd) begin
                        bg_s[p+j] = 1'b0;
                        e = p + j + 1;
                        abrt = 1'b1;
                        break;
                    end
                end
            end else begin
                c = p;
                if (k == 0) begin
                    for (int b = 0; b < DW; b++) begin
                        sv_s[c] = 1'b1; mr_s[c] = sd[b]; c++;
                    end
                end else begin
                    for (int b = 0; b < k - sw; b++) begin
                        sv_s[c] = 1'b1; mr_s[c] = sd[b]; c++;
                    end
                    s = c;
                    for (int i = 0; i < l; i++) begin
                        ms_s[s+i] = 1'b1;
                        bg_s[s+i] = (i == 0);
                    end
                    if (sw != 0) begin
                        sv_s[s] = 1'b1; mr_s[s] = sd[k-1];
                    end
                    c = s + l + 1;
                    for (int b = k; b < DW; b++) begin
                        sv_s[c] = 1'b1; mr_s[c] = sd[b]; c++;
                    end
                end
                e = c;
            end
        end
        for (int i = 1; i < e; i++) begin
            exp_v[i][5] = 1'b1;
            exp_v[i][4] = mode;
        end
        if (abrt) exp_v[e][0] = 1'b1;
        else      exp_v[e][1] = 1'b1;
        exp_v[e+1][6] = 1'b1;
        n_cyc = e + 2;
        end_cyc = e;
        exp_rd_load = !abrt && !mode;
        if (exp_rd_load) model_rd = sd;
    endtask

    // Apply the schedule; the request fields are scrambled after cycle 0 to prove latching
    task automatic run_txn(input logic mode, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        for (int c = 0; c < n_cyc; c++) begin
            dvalid = (c == 0);
            dmode  = (c == 0) ? mode : 1'($urandom);
            daddr  = (c == 0) ? addr : AW'($urandom);
            dwdata = (c == 0) ? wd : DW'($urandom);
            bgrant = bg_s[c]; ack = ack_s[c]; svalid = sv_s[c];
            msplit = ms_s[c]; mrdata = mr_s[c];
            obs_v[c]  = {dready, breq, mmode, mvalid, mwdata, ddone, derror};
            obs_rd[c] = drdata;
            @(posedge clk); #1;
        end
        dvalid = 1'b0; bgrant = 1'b0; ack = 1'b0; svalid = 1'b0; msplit = 1'b0; mrdata = 1'b0;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        dvalid = 1'b0; dmode = 1'b0; daddr = '0; dwdata = '0;
        bgrant = 1'b0; msplit = 1'b0; ack = 1'b0; mrdata = 1'b0; svalid = 1'b0;
        #2;
        checks++;
        if ({dready, breq, mmode, mvalid, mwdata, ddone, derror} !== 7'b1000000) begin
            $display("FAIL reset_outputs: got %b expected %b",
                     {dready, breq, mmode, mvalid, mwdata, ddone, derror}, 7'b1000000);
            fails++;
        end
        checks++;
        if (drdata !== 8'h00) begin
            $display("FAIL reset_drdata: got %h expected %h", drdata, 8'h00);
            fails++;
        end
        #10 rstn = 1'b1;
        model_rd = 8'h00;
        @(posedge clk); #1;
    endtask

    task automatic test_write_basic;
        int first;
        plan(1'b1, 16'h1234, 8'hA5, 8'h00, 0, 0, 0, 0, -1);
        run_txn(1'b1, 16'h1234, 8'hA5);
        first = -1;
        for (int c = 0; c < n_cyc; c++) begin
            checks++;
            if (obs_v[c] !== exp_v[c]) begin
                $display("FAIL write_basic cycle %0d: got %b expected %b", c, obs_v[c], exp_v[c]);
                fails++;
            end
            if (obs_v[c][1] && first < 0) first = c;
        end
        checks++;
        if (first != 27) begin
            $display("FAIL write_basic_latency: ddone cycle %0d expected %0d", first, 27);
            fails++;
        end
    endtask

    task automatic test_read_basic;
        plan(1'b0, 16'hBEEF, 8'h00, 8'h3C, 0, 0, 0, 0, -1);
        run_txn(1'b0, 16'hBEEF, 8'h00);
        for (int c = 0; c < n_cyc; c++) begin
            checks++;
            if (obs_v[c] !== exp_v[c]) begin
                $display("FAIL read_basic cycle %0d: got %b expected %b", c, obs_v[c], exp_v[c]);
                fails++;
            end
        end
        checks++;
        if (obs_rd[end_cyc] !== 8'h3C || obs_rd[end_cyc+1] !== 8'h3C) begin
            $display("FAIL read_basic_data: got %h/%h expected %h",
                     obs_rd[end_cyc], obs_rd[end_cyc+1], 8'h3C);
            fails++;
        end
    endtask

    task automatic test_read_split;
        plan(1'b0, 16'h0F0F, 8'h00, 8'hC9, 1, 3, 10, 0, -1);
        run_txn(1'b0, 16'h0F0F, 8'h00);
        for (int c = 0; c < n_cyc; c++) begin
            checks++;
            if (obs_v[c] !== exp_v[c]) begin
                $display("FAIL read_split cycle %0d: got %b expected %b", c, obs_v[c], exp_v[c]);
                fails++;
            end
        end
        checks++;
        if (obs_rd[end_cyc] !== 8'hC9) begin
            $display("FAIL read_split_data: got %h expected %h", obs_rd[end_cyc], 8'hC9);
            fails++;
        end
    endtask

    task automatic test_ack_timeout;
        // never acked: abort, then boundary ack exactly at the timeout count is accepted
        plan(1'b1, 16'h00FF, 8'h11, 8'h00, -1, 0, 0, 0, -1);
        run_txn(1'b1, 16'h00FF, 8'h11);
        for (int c = 0; c < n_cyc; c++) begin
            checks++;
            if (obs_v[c] !== exp_v[c]) begin
                $display("FAIL ack_timeout cycle %0d: got %b expected %b", c, obs_v[c], exp_v[c]);
                fails++;
            end
        end
        checks++;
        if (obs_rd[end_cyc+1] !== model_rd) begin
            $display("FAIL ack_timeout_drdata: got %h expected %h", obs_rd[end_cyc+1], model_rd);
            fails++;
        end
        plan(1'b0, 16'h8001, 8'h00, 8'h96, TO, 0, 0, 0, -1);
        run_txn(1'b0, 16'h8001, 8'h00);
        for (int c = 0; c < n_cyc; c++) begin
            checks++;
            if (obs_v[c] !== exp_v[c]) begin
                $display("FAIL ack_late cycle %0d: got %b expected %b", c, obs_v[c], exp_v[c]);
                fails++;
            end
        end
        checks++;
        if (obs_rd[end_cyc] !== 8'h96) begin
            $display("FAIL ack_late_data: got %h expected %h", obs_rd[end_cyc], 8'h96);
            fails++;
        end
    endtask

    task automatic test_grant_drop;
        plan(1'b1, 16'h4321, 8'h5E, 8'h00, 2, 0, 0, 0, 3);
        run_txn(1'b1, 16'h4321, 8'h5E);
        for (int c = 0; c < n_cyc; c++) begin
            checks++;
            if (obs_v[c] !== exp_v[c]) begin
                $display("FAIL grant_drop cycle %0d: got %b expected %b", c, obs_v[c], exp_v[c]);
                fails++;
            end
        end
    endtask

    task automatic test_random;
        logic          m;
        logic [AW-1:0] a;
        logic [DW-1:0] w, s;
        int            d, k, l, sw, gd;
        for (int t = 0; t < 10; t++) begin
            m  = 1'($urandom);
            a  = AW'($urandom);
            w  = DW'($urandom);
            s  = DW'($urandom);
            d  = $urandom_range(0, TO);
            k  = m ? 0 : $urandom_range(0, DW - 1);
            l  = $urandom_range(1, 12);
            sw = (k > 0) ? $urandom_range(0, 1) : 0;
            gd = (m && $urandom_range(0, 3) == 0) ? $urandom_range(0, DW - 1) : -1;
            plan(m, a, w, s, d, k, l, sw, gd);
            run_txn(m, a, w);
            for (int c = 0; c < n_cyc; c++) begin
                checks++;
                if (obs_v[c] !== exp_v[c]) begin
                    $display("FAIL random txn %0d cycle %0d: got %b expected %b",
                             t, c, obs_v[c], exp_v[c]);
                    fails++;
                end
            end
            checks++;
            if (obs_rd[end_cyc+1] !== model_rd) begin
                $display("FAIL random txn %0d drdata: got %h expected %h",
                         t, obs_rd[end_cyc+1], model_rd);
                fails++;
            end
        end
    endtask

    task automatic test_async_reset;
        plan(1'b1, 16'hFFFF, 8'hFF, 8'h00, 0, 0, 0, 0, -1);
        n_cyc = 6;
        run_txn(1'b1, 16'hFFFF, 8'hFF);
        bgrant = 1'b1;
        checks++;
        if ({breq, mvalid} !== 2'b11) begin
            $display("FAIL async_reset_pre: got %b expected %b", {breq, mvalid}, 2'b11);
            fails++;
        end
        #3 rstn = 1'b0;
        #1;
        checks++;
        if ({dready, breq, mvalid, mwdata, ddone, derror} !== 6'b100000) begin
            $display("FAIL async_reset_now: got %b expected %b",
                     {dready, breq, mvalid, mwdata, ddone, derror}, 6'b100000);
            fails++;
        end
        model_rd = 8'h00;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (i == 2) rstn = 1'b1;
            checks++;
            if ({dready, breq, ddone, derror, drdata} !== {4'b1000, model_rd}) begin
                $display("FAIL async_reset_after %0d: got %b expected %b", i,
                         {dready, breq, ddone, derror, drdata}, {4'b1000, model_rd});
                fails++;
            end
        end
        bgrant = 1'b0;
        plan(1'b1, 16'h2468, 8'h3B, 8'h00, 1, 0, 0, 0, -1);
        run_txn(1'b1, 16'h2468, 8'h3B);
        for (int c = 0; c < n_cyc; c++) begin
            checks++;
            if (obs_v[c] !== exp_v[c]) begin
                $display("FAIL post_reset_write cycle %0d: got %b expected %b",
                         c, obs_v[c], exp_v[c]);
                fails++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read_basic();
        test_read_split();
        test_ack_timeout();
        test_grant_drop();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
